discus_memsys: RTL and testbench

- Responder end of the discus CPU memory and fetch ports.
- Holds a 256x8 program RAM, loaded from a host byte stream while the CPU is held in reset.
- Holds a 256x8 data RAM with a small memory-mapped I/O window.
- The I/O window fronts a TX FIFO (CPU→host) and an RX FIFO (host→CPU), both with valid/ready handshakes.

---
 rtl/discus_memsys_if.sv | 38 +++
 rtl/discus_memsys.sv | 198 +++++++++++++++++++
 tb/tb_discus_memsys.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/discus_memsys_if.sv
// Bus bundle between the discus CPU/host side and the memory system responder.
// master = CPU fetch/data ports plus host load/tx/rx endpoints; slave = discus_memsys.
interface discus_memsys_if;
    logic [7:0] fetch_PC;
    logic       fetch_reset;
    logic [7:0] fetch_instruction;

    logic       memory_read;
    logic       memory_write;
    logic [7:0] memory_address;
    logic [7:0] memory_D;
    logic [7:0] memory_Q;

    logic       load_valid;
    logic       load_ready;
    logic [7:0] load_data;
    logic       load_last;

    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;

    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] rx_data;

    modport master (
        output fetch_PC, fetch_reset, memory_read, memory_write, memory_address, memory_D,
        output load_valid, load_data, load_last, tx_ready, rx_valid, rx_data,
        input  fetch_instruction, memory_Q, load_ready, tx_valid, tx_data, rx_ready
    );

    modport slave (
        input  fetch_PC, fetch_reset, memory_read, memory_write, memory_address, memory_D,
        input  load_valid, load_data, load_last, tx_ready, rx_valid, rx_data,
        output fetch_instruction, memory_Q, load_ready, tx_valid, tx_data, rx_ready
    );
endinterface

// File: rtl/discus_memsys.sv
// discus memory responder: program RAM with host loader, data RAM, and an I/O
// window fronting TX (CPU->host) and RX (host->CPU) byte FIFOs.
module discus_memsys #(
    parameter logic [7:0] IO_BASE  = 8'hF0,
    parameter int         TX_DEPTH = 4,
    parameter int         RX_DEPTH = 4
) (
    input  logic           clk,
    input  logic           reset,
    output logic           cpu_reset,
    discus_memsys_if.slave bus
);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam logic [TX_AW:0] TX_FULL_CNT = {1'b1, {TX_AW{1'b0}}};
    localparam logic [RX_AW:0] RX_FULL_CNT = {1'b1, {RX_AW{1'b0}}};

    localparam logic [0:0] ST_LOAD = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;
    localparam logic [7:0] NOP     = 8'hC8;

    localparam logic [1:0] RESP_NONE = 2'd0;
    localparam logic [1:0] RESP_RAM  = 2'd1;
    localparam logic [1:0] RESP_IO   = 2'd2;

    logic [7:0] prog_mem [256];
    logic [7:0] data_mem [256];
    logic [7:0] tx_mem   [TX_DEPTH];
    logic [7:0] rx_mem   [RX_DEPTH];

    logic [0:0]     state_q, state_d;
    logic [7:0]     load_ptr_q, load_ptr_d;
    logic           cpu_reset_q, cpu_reset_d;
    logic           fetch_nop_q, fetch_nop_d;
    logic [7:0]     prog_rd_q;
    logic [7:0]     data_rd_q;
    logic [1:0]     resp_q, resp_d;
    logic [7:0]     io_rd_q, io_rd_d;
    logic [TX_AW-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
    logic [TX_AW:0]   tx_count_q, tx_count_d;
    logic [RX_AW-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
    logic [RX_AW:0]   rx_count_q, rx_count_d;
    logic           tx_overflow_q, tx_overflow_d;

    logic       load_fire;
    logic [7:0] io_off;
    logic       io_hit;
    logic       rd_en;
    logic       wr_en;
    logic       tx_full, tx_empty, tx_pop, tx_push_req, tx_push;
    logic       rx_full, rx_empty, rx_pop, rx_push;
    logic       status_rd;

    assign load_fire = (state_q == ST_LOAD) && bus.load_valid;

    // Window test by offset so an IO_BASE near the top of the map does not wrap.
    assign io_off = bus.memory_address - IO_BASE;
    assign io_hit = (bus.memory_address >= IO_BASE) && (io_off < 8'd16);

    // A simultaneous write wins; the read is dropped and returns no data.
    assign rd_en = bus.memory_read && !bus.memory_write;
    assign wr_en = bus.memory_write;

    assign tx_full     = (tx_count_q == TX_FULL_CNT);
    assign tx_empty    = (tx_count_q == '0);
    assign tx_pop      = !tx_empty && bus.tx_ready;
    assign tx_push_req = wr_en && io_hit && (io_off == 8'd0);
    assign tx_push     = tx_push_req && (!tx_full || tx_pop);

    assign rx_full   = (rx_count_q == RX_FULL_CNT);
    assign rx_empty  = (rx_count_q == '0);
    assign rx_pop    = rd_en && io_hit && (io_off == 8'd0) && !rx_empty;
    assign rx_push   = bus.rx_valid && !rx_full;
    assign status_rd = rd_en && io_hit && (io_off == 8'd1);

    always_comb begin
        state_d     = state_q;
        load_ptr_d  = load_ptr_q;
        if (load_fire) begin
            load_ptr_d = load_ptr_q + 8'd1;
            if (bus.load_last || (load_ptr_q == 8'hFF)) begin
                state_d = ST_RUN;
            end
        end
        cpu_reset_d = (state_q == ST_LOAD);
        fetch_nop_d = (state_q == ST_LOAD) || bus.fetch_reset;

        resp_d  = RESP_NONE;
        io_rd_d = 8'h00;
        if (rd_en) begin
            if (io_hit) begin
                resp_d = RESP_IO;
                if (io_off == 8'd0) begin
                    io_rd_d = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr_q];
                end else if (io_off == 8'd1) begin
                    io_rd_d = {5'b0, tx_overflow_q, !rx_empty, tx_full};
                end
            end else begin
                resp_d = RESP_RAM;
            end
        end

        tx_overflow_d = tx_overflow_q;
        if (status_rd) begin
            tx_overflow_d = 1'b0;
        end
        if (tx_push_req && !tx_push) begin
            tx_overflow_d = 1'b1;
        end

        tx_wr_ptr_d = tx_push ? tx_wr_ptr_q + 1'b1 : tx_wr_ptr_q;
        tx_rd_ptr_d = tx_pop  ? tx_rd_ptr_q + 1'b1 : tx_rd_ptr_q;
        case ({tx_push, tx_pop})
            2'b10:   tx_count_d = tx_count_q + 1'b1;
            2'b01:   tx_count_d = tx_count_q - 1'b1;
            default: tx_count_d = tx_count_q;
        endcase

        rx_wr_ptr_d = rx_push ? rx_wr_ptr_q + 1'b1 : rx_wr_ptr_q;
        rx_rd_ptr_d = rx_pop  ? rx_rd_ptr_q + 1'b1 : rx_rd_ptr_q;
        case ({rx_push, rx_pop})
            2'b10:   rx_count_d = rx_count_q + 1'b1;
            2'b01:   rx_count_d = rx_count_q - 1'b1;
            default: rx_count_d = rx_count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_LOAD;
            load_ptr_q    <= 8'h00;
            cpu_reset_q   <= 1'b1;
            fetch_nop_q   <= 1'b1;
            resp_q        <= RESP_NONE;
            io_rd_q       <= 8'h00;
            tx_wr_ptr_q   <= '0;
            tx_rd_ptr_q   <= '0;
            tx_count_q    <= '0;
            rx_wr_ptr_q   <= '0;
            rx_rd_ptr_q   <= '0;
            rx_count_q    <= '0;
            tx_overflow_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            load_ptr_q    <= load_ptr_d;
            cpu_reset_q   <= cpu_reset_d;
            fetch_nop_q   <= fetch_nop_d;
            resp_q        <= resp_d;
            io_rd_q       <= io_rd_d;
            tx_wr_ptr_q   <= tx_wr_ptr_d;
            tx_rd_ptr_q   <= tx_rd_ptr_d;
            tx_count_q    <= tx_count_d;
            rx_wr_ptr_q   <= rx_wr_ptr_d;
            rx_rd_ptr_q   <= rx_rd_ptr_d;
            rx_count_q    <= rx_count_d;
            tx_overflow_q <= tx_overflow_d;
        end
    end

    // RAM ports kept free of reset so they map onto block RAM; writes are gated by reset.
    always_ff @(posedge clk) begin
        if (reset && load_fire) begin
            prog_mem[load_ptr_q] <= bus.load_data;
        end
        prog_rd_q <= prog_mem[bus.fetch_PC];
    end

    always_ff @(posedge clk) begin
        if (reset && wr_en && !io_hit) begin
            data_mem[bus.memory_address] <= bus.memory_D;
        end
        data_rd_q <= data_mem[bus.memory_address];
    end

    always_ff @(posedge clk) begin
        if (reset && tx_push) begin
            tx_mem[tx_wr_ptr_q] <= bus.memory_D;
        end
        if (reset && rx_push) begin
            rx_mem[rx_wr_ptr_q] <= bus.rx_data;
        end
    end

    assign cpu_reset             = cpu_reset_q;
    assign bus.load_ready        = (state_q == ST_LOAD);
    assign bus.fetch_instruction = fetch_nop_q ? NOP : prog_rd_q;
    assign bus.tx_valid          = !tx_empty;
    assign bus.tx_data           = tx_mem[tx_rd_ptr_q];
    assign bus.rx_ready          = !rx_full;

    always_comb begin
        case (resp_q)
            RESP_RAM: bus.memory_Q = data_rd_q;
            RESP_IO:  bus.memory_Q = io_rd_q;
            default:  bus.memory_Q = 8'h00;
        endcase
    end
endmodule

// File: tb/tb_discus_memsys.sv
// Self-checking bench for discus_memsys: fetch vector table, directed load/IO
// sequences, and a randomized data-port run against a queue-based model.
module tb_discus_memsys;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic cpu_reset;

    discus_memsys_if bus_if();

    discus_memsys #(.IO_BASE(8'hF0), .TX_DEPTH(4), .RX_DEPTH(4)) dut (
        .clk(clk),
        .reset(reset),
        .cpu_reset(cpu_reset),
        .bus(bus_if)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0] pc;
        logic       frst;
        logic [7:0] exp;
    } fvec_t;
    fvec_t fv [6];

    logic [7:0] mram [256];
    bit         mknown [256];
    logic [7:0] tx_m [$];
    logic [7:0] rx_m [$];
    bit         m_ovf;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%02h, want 0x%02h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus_if.fetch_PC       = 8'h00;
        bus_if.fetch_reset    = 1'b0;
        bus_if.memory_read    = 1'b0;
        bus_if.memory_write   = 1'b0;
        bus_if.memory_address = 8'h00;
        bus_if.memory_D       = 8'h00;
        bus_if.load_valid     = 1'b0;
        bus_if.load_data      = 8'h00;
        bus_if.load_last      = 1'b0;
        bus_if.tx_ready       = 1'b0;
        bus_if.rx_valid       = 1'b0;
        bus_if.rx_data        = 8'h00;
    endtask

    task automatic cpu_op(input logic rd, input logic wr, input logic [7:0] addr, input logic [7:0] d);
        bus_if.memory_read    = rd;
        bus_if.memory_write   = wr;
        bus_if.memory_address = addr;
        bus_if.memory_D       = d;
    endtask

    initial begin
        idle_inputs();
        fv[0] = '{pc: 8'h00, frst: 1'b0, exp: 8'h01};
        fv[1] = '{pc: 8'h01, frst: 1'b0, exp: 8'h02};
        fv[2] = '{pc: 8'h02, frst: 1'b0, exp: 8'h03};
        fv[3] = '{pc: 8'h00, frst: 1'b1, exp: 8'hC8};
        fv[4] = '{pc: 8'h02, frst: 1'b1, exp: 8'hC8};
        fv[5] = '{pc: 8'h01, frst: 1'b0, exp: 8'h02};

        // Reset state
        reset = 1'b0;
        step();
        step();
        check("rst_cpu_reset", 8'(cpu_reset), 8'h01);
        check("rst_memory_Q", bus_if.memory_Q, 8'h00);
        check("rst_fetch", bus_if.fetch_instruction, 8'hC8);
        check("rst_load_ready", 8'(bus_if.load_ready), 8'h01);
        check("rst_tx_valid", 8'(bus_if.tx_valid), 8'h00);
        check("rst_rx_ready", 8'(bus_if.rx_ready), 8'h01);
        $display("reset applied");
        reset = 1'b1;

        // Load three bytes
        for (int i = 0; i < 3; i++) begin
            bus_if.load_valid = 1'b1;
            bus_if.load_data  = 8'(i + 1);
            bus_if.load_last  = (i == 2);
            #1;
            check("load_ready_during_load", 8'(bus_if.load_ready), 8'h01);
            step();
            $display("load byte 0x%02h", 8'(i + 1));
        end
        bus_if.load_valid = 1'b0;
        bus_if.load_last  = 1'b0;
        check("load_ready_after_last", 8'(bus_if.load_ready), 8'h00);
        check("cpu_reset_1_after_last", 8'(cpu_reset), 8'h01);
        step();
        check("cpu_reset_2_after_last", 8'(cpu_reset), 8'h00);
        check("load_ready_run", 8'(bus_if.load_ready), 8'h00);

        // Fetch table
        for (int i = 0; i < 6; i++) begin
            bus_if.fetch_PC    = fv[i].pc;
            bus_if.fetch_reset = fv[i].frst;
            step();
            check($sformatf("fetch_vec%0d", i), bus_if.fetch_instruction, fv[i].exp);
            $display("fetch pc=0x%02h rst=%0d -> 0x%02h", fv[i].pc, fv[i].frst, bus_if.fetch_instruction);
        end
        bus_if.fetch_reset = 1'b0;
        bus_if.fetch_PC    = 8'h00;

        // Write then read RAM
        cpu_op(1'b0, 1'b1, 8'h10, 8'h5A);
        step();
        cpu_op(1'b1, 1'b0, 8'h10, 8'h00);
        check("memQ_before_read", bus_if.memory_Q, 8'h00);
        step();
        cpu_op(1'b0, 1'b0, 8'h00, 8'h00);
        check("memQ_read_0x10", bus_if.memory_Q, 8'h5A);
        step();
        check("memQ_after_read", bus_if.memory_Q, 8'h00);
        $display("ram write/read 0x10");

        // Read+write together: write done, read dropped
        cpu_op(1'b1, 1'b1, 8'h11, 8'h33);
        step();
        cpu_op(1'b1, 1'b0, 8'h11, 8'h00);
        check("memQ_rw_together", bus_if.memory_Q, 8'h00);
        step();
        cpu_op(1'b0, 1'b0, 8'h00, 8'h00);
        check("memQ_rw_write_done", bus_if.memory_Q, 8'h33);
        $display("ram read+write 0x11");

        // TX overflow
        bus_if.tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cpu_op(1'b0, 1'b1, 8'hF0, 8'(8'h41 + i));
            step();
            $display("tx push 0x%02h", 8'(8'h41 + i));
        end
        cpu_op(1'b1, 1'b0, 8'hF1, 8'h00);
        #1;
        check("tx_valid_full", 8'(bus_if.tx_valid), 8'h01);
        check("tx_head", bus_if.tx_data, 8'h41);
        step();
        check("status_overflow", bus_if.memory_Q, 8'h05);
        step();
        cpu_op(1'b0, 1'b0, 8'h00, 8'h00);
        check("status_cleared", bus_if.memory_Q, 8'h01);
        bus_if.tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("tx_drain_valid", 8'(bus_if.tx_valid), 8'h01);
            check("tx_drain_data", bus_if.tx_data, 8'(8'h41 + i));
            step();
            $display("tx pop expected 0x%02h", 8'(8'h41 + i));
        end
        check("tx_empty_after_drain", 8'(bus_if.tx_valid), 8'h00);
        bus_if.tx_ready = 1'b0;

        // RX single byte
        bus_if.rx_valid = 1'b1;
        bus_if.rx_data  = 8'h99;
        #1;
        check("rx_ready_empty", 8'(bus_if.rx_ready), 8'h01);
        step();
        bus_if.rx_valid = 1'b0;
        cpu_op(1'b1, 1'b0, 8'hF1, 8'h00);
        step();
        check("status_rx_nonempty", bus_if.memory_Q, 8'h02);
        cpu_op(1'b1, 1'b0, 8'hF0, 8'h00);
        step();
        check("rx_read", bus_if.memory_Q, 8'h99);
        step();
        cpu_op(1'b0, 1'b0, 8'h00, 8'h00);
        check("rx_read_empty", bus_if.memory_Q, 8'h00);
        step();
        check("memQ_idle_after_rx", bus_if.memory_Q, 8'h00);
        $display("rx byte 0x99 read back");

        // Randomized data-port run against the model
        for (int a = 0; a < 256; a++) mknown[a] = 1'b0;
        mram[8'h10] = 8'h5A; mknown[8'h10] = 1'b1;
        mram[8'h11] = 8'h33; mknown[8'h11] = 1'b1;
        m_ovf = 1'b0;
        tx_m.delete();
        rx_m.delete();
        for (int cyc = 0; cyc < 300; cyc++) begin
            int op, r;
            bit rd, wr, io;
            logic [7:0] addr, d, exp_next, off;
            bit exp_known;
            int rx_pre;
            op = $urandom_range(0, 3);
            rd = (op == 1) || (op == 3);
            wr = (op == 2) || (op == 3);
            io = ($urandom_range(0, 1) == 1);
            if (io) begin
                r = $urandom_range(0, 4);
                off = (r < 2) ? 8'd0 : (r == 2) ? 8'd1 : (r == 3) ? 8'd2 : 8'd15;
                addr = 8'hF0 + off;
            end else begin
                off = 8'd0;
                addr = 8'h20 + 8'($urandom_range(0, 7));
            end
            d = 8'($urandom_range(0, 255));
            cpu_op(rd, wr, addr, d);
            bus_if.tx_ready = ($urandom_range(0, 2) == 0);
            bus_if.rx_valid = ($urandom_range(0, 1) == 1);
            bus_if.rx_data  = 8'($urandom_range(0, 255));
            #1;
            check("rand_tx_valid", 8'(bus_if.tx_valid), 8'(tx_m.size() != 0));
            if (tx_m.size() != 0) check("rand_tx_data", bus_if.tx_data, tx_m[0]);
            check("rand_rx_ready", 8'(bus_if.rx_ready), 8'(rx_m.size() < 4));

            rx_pre = rx_m.size();
            exp_next = 8'h00;
            exp_known = 1'b1;
            if (rd && !wr) begin
                if (io) begin
                    if (off == 8'd0) begin
                        if (rx_m.size() != 0) exp_next = rx_m.pop_front();
                    end else if (off == 8'd1) begin
                        exp_next = {5'b0, m_ovf, rx_m.size() != 0, tx_m.size() == 4};
                        m_ovf = 1'b0;
                    end
                end else if (mknown[addr]) begin
                    exp_next = mram[addr];
                end else begin
                    exp_known = 1'b0;
                end
            end
            if ((tx_m.size() != 0) && bus_if.tx_ready) void'(tx_m.pop_front());
            if (wr && io && (off == 8'd0)) begin
                if (tx_m.size() < 4) tx_m.push_back(d);
                else m_ovf = 1'b1;
            end
            if (wr && !io) begin
                mram[addr] = d;
                mknown[addr] = 1'b1;
            end
            if (bus_if.rx_valid && (rx_pre < 4)) rx_m.push_back(bus_if.rx_data);

            step();
            if (exp_known) check("rand_memory_Q", bus_if.memory_Q, exp_next);
            $display("rand cyc=%0d rd=%0d wr=%0d addr=0x%02h d=0x%02h Q=0x%02h", cyc, rd, wr, addr, d, bus_if.memory_Q);
        end
        idle_inputs();
        step();

        // Reset mid-run with FIFOs occupied, then mid-load abort and reload
        cpu_op(1'b0, 1'b1, 8'hF0, 8'h77);
        bus_if.rx_valid = 1'b1;
        bus_if.rx_data  = 8'h55;
        step();
        idle_inputs();
        reset = 1'b0;
        step();
        reset = 1'b1;
        #1;
        check("rerst_tx_valid", 8'(bus_if.tx_valid), 8'h00);
        check("rerst_rx_ready", 8'(bus_if.rx_ready), 8'h01);
        check("rerst_cpu_reset", 8'(cpu_reset), 8'h01);
        check("rerst_fetch", bus_if.fetch_instruction, 8'hC8);
        cpu_op(1'b1, 1'b0, 8'hF1, 8'h00);
        step();
        cpu_op(1'b0, 1'b0, 8'h00, 8'h00);
        check("rerst_status", bus_if.memory_Q, 8'h00);
        $display("reset mid-run");

        bus_if.load_valid = 1'b1;
        bus_if.load_data  = 8'hAA;
        step();
        bus_if.load_data  = 8'hBB;
        step();
        bus_if.load_valid = 1'b0;
        reset = 1'b0;
        step();
        reset = 1'b1;
        $display("reset mid-load after 2 bytes");
        for (int i = 0; i < 3; i++) begin
            check("midload_cpu_reset", 8'(cpu_reset), 8'h01);
            check("midload_load_ready", 8'(bus_if.load_ready), 8'h01);
            step();
        end
        bus_if.load_valid = 1'b1;
        bus_if.load_data  = 8'hE7;
        bus_if.load_last  = 1'b1;
        step();
        bus_if.load_valid = 1'b0;
        bus_if.load_last  = 1'b0;
        check("reload_cpu_reset_1", 8'(cpu_reset), 8'h01);
        step();
        check("reload_cpu_reset_2", 8'(cpu_reset), 8'h00);
        bus_if.fetch_PC = 8'h00;
        step();
        check("reload_prog0", bus_if.fetch_instruction, 8'hE7);
        bus_if.fetch_PC = 8'h01;
        step();
        check("reload_prog1_kept", bus_if.fetch_instruction, 8'hBB);
        $display("reload byte 0xE7");

        // Full 256-byte load ends itself at ptr=255
        reset = 1'b0;
        step();
        reset = 1'b1;
        for (int i = 0; i < 256; i++) begin
            bus_if.load_valid = 1'b1;
            bus_if.load_data  = 8'(i) ^ 8'h5A;
            if (i == 255) begin
                #1;
                check("load255_ready", 8'(bus_if.load_ready), 8'h01);
            end
            step();
        end
        bus_if.load_valid = 1'b0;
        check("load256_done", 8'(bus_if.load_ready), 8'h00);
        bus_if.fetch_PC = 8'hFF;
        step();
        check("load256_prog255", bus_if.fetch_instruction, 8'hA5);
        bus_if.fetch_PC = 8'h80;
        step();
        check("load256_prog128", bus_if.fetch_instruction, 8'hDA);
        $display("full 256-byte load");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
